// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares the frame-buffer BRAM port between display fetch and client write/read ports; FB_ARB_STATS_EN adds a stall counter
module fb_access_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_pixel,
  output logic              disp_pixel_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef FB_ARB_STATS_EN
  ,output logic [15:0]      stall_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE, COOL} state_t;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic rr_q, rr_d;
  logic oor_q, oor_d;
  logic dv1_q, dv1_d, dv2_q, dv2_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, err_q, err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] disp_pixel_q, disp_pixel_d;
  logic disp_pixel_valid_q, disp_pixel_valid_d;
  logic wr_oor, rd_oor, gnt_wr, gnt_rd;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
`endif
  // Grant decision (blanking + idle only, rr_q=1 favours read on a tie), next state and next registered outputs
  always_comb begin
    wr_oor = {1'b0, wr_addr} >= LIMIT;
    rd_oor = {1'b0, rd_addr} >= LIMIT;
    gnt_wr = state_q == IDLE && !disp_valid && wr_req && (!rd_req || !rr_q);
    gnt_rd = state_q == IDLE && !disp_valid && rd_req && (!wr_req || rr_q);
    state_d = gnt_wr ? WR :
              gnt_rd ? RD_ISSUE :
              state_q == WR ? COOL :
              state_q == RD_ISSUE ? RD_WAIT :
              state_q == RD_WAIT ? RD_DONE :
              state_q == RD_DONE ? COOL :
              state_q == COOL ? IDLE : state_q;
    rr_d = gnt_wr ? 1'b1 : gnt_rd ? 1'b0 : rr_q;
    oor_d = gnt_rd ? rd_oor : oor_q;
    mem_en_d = disp_valid || (gnt_wr && !wr_oor) || (gnt_rd && !rd_oor);
    mem_we_d = gnt_wr && !wr_oor;
    mem_addr_d = !mem_en_d ? '0 : gnt_wr ? wr_addr : gnt_rd ? rd_addr : disp_addr;
    mem_din_d = mem_we_d ? wr_data : '0;
    wr_ack_d = gnt_wr;
    rd_ack_d = state_q == RD_WAIT;
    err_d = (gnt_wr && wr_oor) || (state_q == RD_WAIT && oor_q);
    rd_data_d = state_q == RD_WAIT ? (oor_q ? '0 : mem_dout) : rd_data_q;
    dv1_d = disp_valid;
    dv2_d = dv1_q;
    disp_pixel_valid_d = dv2_q;
    disp_pixel_d = dv2_q ? mem_dout : '0;
`ifdef FB_ARB_STATS_EN
    stall_cnt_d = ((wr_req || rd_req) && !wr_ack_q && !rd_ack_q && disp_valid && stall_cnt_q != 16'hFFFF) ?
                  stall_cnt_q + 16'd1 : stall_cnt_q;
`endif
  end
  // State and output registers; reset abandons any in-flight client op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      oor_q <= 1'b0;
      dv1_q <= 1'b0;
      dv2_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      disp_pixel_q <= '0;
      disp_pixel_valid_q <= 1'b0;
`ifdef FB_ARB_STATS_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      oor_q <= oor_d;
      dv1_q <= dv1_d;
      dv2_q <= dv2_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      disp_pixel_q <= disp_pixel_d;
      disp_pixel_valid_q <= disp_pixel_valid_d;
`ifdef FB_ARB_STATS_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end
  assign disp_pixel = disp_pixel_q;
  assign disp_pixel_valid = disp_pixel_valid_q;
  assign wr_ack = wr_ack_q;
  assign rd_ack = rd_ack_q;
  assign rd_data = rd_data_q;
  assign err = err_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
`ifdef FB_ARB_STATS_EN
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: scoreboard bench with BRAM model and shadow-memory reference
module tb_fb_access_arbiter;
  localparam int DEPTH = 76800;
  logic clk = 1'b0;
  logic rst, disp_valid, wr_req, rd_req;
  logic [16:0] disp_addr, wr_addr, rd_addr, mem_addr;
  logic [11:0] disp_pixel, wr_data, rd_data, mem_din, mem_dout;
  logic disp_pixel_valid, wr_ack, rd_ack, err, mem_en, mem_we;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif
  typedef struct {bit rd; logic [16:0] addr; logic [11:0] data;} op_t;
  typedef struct {logic [11:0] v; int c;} px_t;
  op_t sb_q[$];
  px_t dq[$];
  logic [11:0] bram [0:DEPTH-1];
  logic [11:0] ref_mem [0:DEPTH-1];
  int tests = 0, failed = 0, cyc = 0, n_wr_ack = 0, n_rd_ack = 0;
  bit prev_dv = 1'b0, prev_rst = 1'b1;
  logic [16:0] prev_da = '0;

  fb_access_arbiter dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_addr(disp_addr),
    .disp_pixel(disp_pixel), .disp_pixel_valid(disp_pixel_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din),
`ifdef FB_ARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .mem_dout(mem_dout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin #500000; $display("FAIL watchdog: run exceeded time limit"); $fatal(1); end

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) bram[mem_addr] = mem_din;
      else mem_dout <= bram[mem_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_pix"}, 32'(disp_pixel), 0);
    chk({nm, "_pixv"}, 32'(disp_pixel_valid), 0);
    chk({nm, "_wack"}, 32'(wr_ack), 0);
    chk({nm, "_rack"}, 32'(rd_ack), 0);
    chk({nm, "_rdata"}, 32'(rd_data), 0);
    chk({nm, "_err"}, 32'(err), 0);
    chk({nm, "_men"}, 32'(mem_en), 0);
    chk({nm, "_mwe"}, 32'(mem_we), 0);
    chk({nm, "_maddr"}, 32'(mem_addr), 0);
    chk({nm, "_mdin"}, 32'(mem_din), 0);
  endtask

  // Monitor: pops the scoreboard on acks, tracks display pixels, checks display ownership of the port
  always @(negedge clk) begin
    op_t e;
    px_t p;
    bit oor;
    if (rst) begin
      sb_q.delete();
      dq.delete();
    end else begin
      if (wr_ack) begin
        n_wr_ack++;
        if (sb_q.size() == 0 || sb_q[0].rd) begin
          tests++; failed++;
          $display("FAIL wr_ack_unexpected: got ack, required none (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          oor = e.addr >= 17'(DEPTH);
          chk("wr_err", 32'(err), 32'(oor));
          chk("wr_mem_en", 32'(mem_en), 32'(!oor));
          if (!oor) begin
            chk("wr_mem_we", 32'(mem_we), 1);
            chk("wr_mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_mem_din", 32'(mem_din), 32'(e.data));
            ref_mem[e.addr] = e.data;
          end
        end
      end
      if (rd_ack) begin
        n_rd_ack++;
        if (sb_q.size() == 0 || !sb_q[0].rd) begin
          tests++; failed++;
          $display("FAIL rd_ack_unexpected: got ack, required none (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          oor = e.addr >= 17'(DEPTH);
          chk("rd_err", 32'(err), 32'(oor));
          chk("rd_data", 32'(rd_data), oor ? 0 : 32'(ref_mem[e.addr]));
        end
      end
      if (disp_valid) dq.push_back('{ref_mem[disp_addr], cyc});
      if (disp_pixel_valid) begin
        if (dq.size() == 0) begin
          tests++; failed++;
          $display("FAIL disp_unexpected: got pixel %0h, required none (cycle %0d)", disp_pixel, cyc);
        end else begin
          p = dq.pop_front();
          chk("disp_pixel", 32'(disp_pixel), 32'(p.v));
          chk("disp_latency", cyc - p.c, 3);
        end
      end else chk("disp_pixel_idle", 32'(disp_pixel), 0);
      if (prev_dv && !prev_rst) begin
        chk("disp_slot_en", 32'(mem_en), 1);
        chk("disp_slot_we", 32'(mem_we), 0);
        chk("disp_slot_addr", 32'(mem_addr), 32'(prev_da));
      end
    end
    prev_dv = disp_valid;
    prev_da = disp_addr;
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic client_op(input bit is_rd, input logic [16:0] a, input logic [11:0] d,
                           input int exp_lat, input string nm);
    int t0, lat;
    sb_q.push_back('{is_rd, a, d});
    if (is_rd) begin rd_req = 1'b1; rd_addr = a; end
    else begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (is_rd ? rd_ack : wr_ack) begin lat = cyc - t0; break; end
    end
    step();
    rd_req = 1'b0;
    wr_req = 1'b0;
    chk({nm, "_acked"}, 32'(lat >= 0), 1);
    if (lat >= 0 && exp_lat >= 0) chk({nm, "_lat"}, lat, exp_lat);
  endtask

  task automatic disp_rand(input int n);
    int run;
    run = 0;
    for (int i = 0; i < n; i++) begin
      if (run == 0) begin
        disp_valid = 1'($urandom_range(0, 1));
        run = disp_valid ? $urandom_range(1, 40) : $urandom_range(1, 12);
      end
      disp_addr = 17'($urandom_range(0, 63));
      run--;
      step();
    end
    disp_valid = 1'b0;
  endtask

  task automatic client_rand(input int n);
    bit r;
    logic [16:0] a;
    for (int k = 0; k < n; k++) begin
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 17'(DEPTH + $urandom_range(0, 40000)) : 17'($urandom_range(0, 63));
      client_op(r, a, 12'($urandom), -1, "rand");
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    int c0, base, nw, nr;
    int wa[2], ra[2];
    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = 12'(i * 37 + 5);
      ref_mem[i] = 12'(i * 37 + 5);
    end
    bram[5] = 12'h123;
    ref_mem[5] = 12'h123;
    rst = 1'b1; disp_valid = 0; wr_req = 0; rd_req = 0;
    disp_addr = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    step();
    // blanking write then readback
    client_op(1'b0, 17'd100, 12'hABC, 1, "blank_wr");
    repeat (2) step();
    client_op(1'b1, 17'd100, 12'h000, 3, "blank_rd");
    repeat (2) step();
    // display fetch latency
    disp_valid = 1'b1; disp_addr = 17'd5;
    step();
    disp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("fetch_pixel", 32'(disp_pixel), 32'h123);
    chk("fetch_valid", 32'(disp_pixel_valid), 1);
    step();
    // display priority over a held write
    base = n_wr_ack;
    sb_q.push_back('{1'b0, 17'd200, 12'h5A5});
    wr_req = 1'b1; wr_addr = 17'd200; wr_data = 12'h5A5;
    for (int i = 0; i < 640; i++) begin
      disp_valid = 1'b1;
      disp_addr = 17'($urandom_range(0, 63));
      step();
    end
    disp_valid = 1'b0;
    @(negedge clk);
    chk("prio_no_ack", n_wr_ack, base);
    @(negedge clk);
    chk("prio_ack_next", 32'(wr_ack), 1);
    step();
    wr_req = 1'b0;
    repeat (2) step();
    // out-of-range client addresses
    client_op(1'b0, 17'd76800, 12'h777, 1, "oor_wr");
    repeat (2) step();
    client_op(1'b1, 17'd80000, 12'h000, 3, "oor_rd");
    repeat (2) step();
    // round robin from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_req = 1'b1; wr_addr = 17'd100; wr_data = 12'h5A5;
    rd_req = 1'b1; rd_addr = 17'd100;
    sb_q.push_back('{1'b0, 17'd100, 12'h5A5});
    sb_q.push_back('{1'b1, 17'd100, 12'h000});
    sb_q.push_back('{1'b0, 17'd100, 12'h5A5});
    sb_q.push_back('{1'b1, 17'd100, 12'h000});
    c0 = cyc; nw = 0; nr = 0;
    wa = '{-1, -1}; ra = '{-1, -1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ack && nw < 2) begin wa[nw] = cyc - c0; nw++; end
      if (rd_ack && nr < 2) begin ra[nr] = cyc - c0; nr++; end
      step();
      if (nw == 2) wr_req = 1'b0;
      if (nr == 2) rd_req = 1'b0;
    end
    chk("rr_wr0", wa[0], 1);
    chk("rr_rd0", ra[0], 6);
    chk("rr_wr1", wa[1], 9);
    chk("rr_rd1", ra[1], 14);
    // randomized traffic with concurrent display
    fork
      disp_rand(1500);
      client_rand(60);
    join
    repeat (10) step();
    chk("sb_drained", sb_q.size(), 0);
    chk("disp_drained", dq.size(), 0);
    // reset while a read is in its wait cycle
    base = n_rd_ack;
    rd_req = 1'b1; rd_addr = 17'd100;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    repeat (6) step();
    chk("rst_mid_no_ack", n_rd_ack, base);
    // stalled write under active video, then reset
    base = n_wr_ack;
    disp_valid = 1'b1; disp_addr = 17'd7;
    wr_req = 1'b1; wr_addr = 17'd300; wr_data = 12'h111;
    repeat (10) step();
    disp_valid = 1'b0; wr_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("stall_no_ack", n_wr_ack, base);
`ifdef FB_ARB_STATS_EN
    chk("stall_cnt10", 32'(stall_cnt), 10);
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_rst");
`ifdef FB_ARB_STATS_EN
    chk("stall_cnt_clr", 32'(stall_cnt), 0);
`endif
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares the single-port 320x240x12 frame-buffer block RAM between three users:
  - the VGA display fetch path;
  - a client write port, used by the drawing/sprite engine;
  - a client read port, used for collision and readback.
- Display fetch has absolute priority during active video. Client operations are served only in slots whose decision cycle sees blanking.
- Sits between the address generator / VGA controller and the BRAM instance, in the 25 MHz pixel clock domain.

Parameters:
- ADDR_W, 17, BRAM address width.
- DATA_W, 12, pixel width (RGB444).
- DEPTH, 76800, valid address count. Client addresses >= DEPTH are out of range.

Ports:
- clk  in  1  pixel clock (25 MHz); all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- disp_valid  in  1  active-video flag from the VGA controller.
- disp_addr  in  ADDR_W  display fetch address.
- disp_pixel  out  DATA_W  fetched pixel; 0 when not valid.
- disp_pixel_valid  out  1  disp_pixel carries fetched data.
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: write committed or rejected.
- rd_req  in  1  read request; held with rd_addr until rd_ack.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read result; held until the next rd_ack.
- rd_ack  out  1  one-cycle pulse: rd_data valid.
- err  out  1  one-cycle pulse with an ack when the client address was out of range.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data; 1-cycle latency after the address edge.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer set so wr wins the first tie.
- Slot pipeline: the decision made in cycle N drives registered mem_* outputs in cycle N+1.
- Display slot (decision cycle N, disp_valid=1):
  - N+1: mem_en=1, mem_we=0, mem_addr=disp_addr sampled at N.
  - N+3: disp_pixel = mem_dout captured at the end of N+2, and disp_pixel_valid=1.
  - Total display latency: 3 cycles. disp_valid is delayed through matching registers.
- If disp_valid=0 at N and no client op is granted: mem_en=0 in N+1, and disp_pixel/disp_pixel_valid go to 0 at N+3.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE, COOL.
- IDLE, when disp_valid=1 at N: no grant. Pending requests wait indefinitely; there is no timeout.
- IDLE, when disp_valid=0 at N and one or more requests are pending:
  - One request is granted.
  - If both are pending, round-robin applies: the port not granted last wins.
  - The pointer updates on every grant.
- Write grant (decision at N):
  - N+1: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_din=wr_data, wr_ack=1. FSM in WR.
  - N+2: FSM in COOL. The requester must drop wr_req or present a new request.
  - N+3: FSM returns to IDLE.
- Read grant (decision at N):
  - N+1: FSM in RD_ISSUE; mem_en=1, mem_we=0.
  - N+2: FSM in RD_WAIT; mem_dout is captured into rd_data.
  - N+3: FSM in RD_DONE; rd_ack=1.
  - Then COOL, then IDLE.
- Port conflicts: during RD_WAIT, RD_DONE and COOL the BRAM port is free for display slots. The client FSM occupies the port only in WR and RD_ISSUE.
- Out-of-range address (addr >= DEPTH):
  - Granted normally, but mem_en=0 in the issue cycle, so no BRAM access.
  - The ack and err pulse at the normal ack cycle.
  - A rejected read returns rd_data=0.
- disp_valid rising mid-read: an already-issued read completes normally. disp_valid falling releases the next decision cycle.
- rst mid-operation:
  - The in-flight op is abandoned and no ack is issued.
  - The requester must re-request.
- Only one client op is outstanding at any time.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt, 16 bits.
  - Counts cycles in which wr_req or rd_req is high, not acked, and disp_valid=1.
  - Saturates at 16'hFFFF and clears on rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Blanking write: disp_valid=0, wr_req with addr 17'd100, data 12'hABC, decision at N -> mem_we=1 and wr_ack=1 at N+1; a later read of 100 returns rd_data=12'hABC with rd_ack at N'+3.
- Display priority: disp_valid=1 for 640 cycles with wr_req held -> mem_we never asserts and there is no wr_ack during that window; first cycle with disp_valid=0 -> mem_we=1 and wr_ack=1 exactly 1 cycle later.
- Display fetch latency: BRAM preloaded with addr 5 = 12'h123, disp_addr=5 with disp_valid=1 at N -> disp_pixel=12'h123 and disp_pixel_valid=1 at N+3.
- Round robin: wr_req and rd_req both asserted in blanking from reset -> grant order wr, rd, wr, rd, with acks 3 cycles apart for wr then 5 cycles for rd.
- Out of range: wr_addr=17'd76800 -> wr_ack=1 and err=1, mem_en=0; rd_addr=17'd80000 -> rd_ack=1, err=1, rd_data=0.
- Reset mid-read: rst asserted in RD_WAIT -> no rd_ack, all outputs 0 the next cycle; with FB_ARB_STATS_EN, 10 stalled cycles before reset -> stall_cnt=10, then 0 after reset.
